calc_seq_ctrl: RTL and testbench

- Sequencing controller for the calculator datapath. Takes single-cycle, already-debounced button events (number load, operator, negate, clear) plus the switch value.
- Keeps the accumulator, the current operand and the pending operator, and launches the multi-cycle ALU through a start/done handshake.
- Drives the value shown by the display driver; also detects errors (divide by zero, ALU error, ALU timeout).

---
 rtl/calc_pkg.sv | 28 ++
 rtl/calc_timeout_cnt.sv | 37 +++
 rtl/calc_seq_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_calc_seq_ctrl.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared opcodes, sequencer state encoding and operand type for the calculator controller.
package calc_pkg;

  localparam int CALC_W = 10;

  localparam logic [2:0] OP_EQ  = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic [2:0] {
    S_A,
    S_B,
    S_EXEC,
    S_WAIT,
    S_RES,
    S_ERR
  } state_e;

  typedef logic signed [CALC_W-1:0] operand_t;

  // 001 and 11x carry no operation; a key press with one of them is a no-op.
  function automatic logic op_reserved(input logic [2:0] code);
    return (code == 3'b001) || (code[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/calc_timeout_cnt.sv
// Wait-cycle counter for the ALU handshake; flags the last permitted wait cycle.
module calc_timeout_cnt #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counter holds at LAST, so expiry lands on exactly the TIMEOUT-th wait cycle.
  assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: key events build operand/accumulator chains and drive a multi-cycle ALU.
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int W       = CALC_W,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [W-1:0]        sw_val,
  input  logic                num_pulse,
  input  logic                op_pulse,
  input  logic [2:0]          op_code,
  input  logic                neg_pulse,
  input  logic                clr_pulse,
  output logic signed [W-1:0] alu_a,
  output logic signed [W-1:0] alu_b,
  output logic [2:0]          alu_op,
  output logic                alu_start,
  input  logic                alu_done,
  input  logic signed [W-1:0] alu_result,
  input  logic                alu_err,
  output logic signed [W-1:0] disp_val,
  output logic                err,
  output logic                busy
);

  state_e              state_q, state_d;
  logic signed [W-1:0] acc_q, acc_d;
  logic signed [W-1:0] operand_q, operand_d;
  logic                opnd_vld_q, opnd_vld_d;
  logic [2:0]          pend_op_q, pend_op_d;
  logic [2:0]          next_op_q, next_op_d;
  logic signed [W-1:0] disp_q, disp_d;
  logic signed [W-1:0] alu_a_q, alu_a_d;
  logic signed [W-1:0] alu_b_q, alu_b_d;
  logic [2:0]          alu_op_q, alu_op_d;
  logic                alu_start_q, alu_start_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;

  logic ev_num, ev_op, ev_neg;
  logic cnt_clr, cnt_en, tmo_expired;

  // Two's complement negation; the most negative value maps onto itself.
  function automatic logic signed [W-1:0] neg_wrap(input logic signed [W-1:0] v);
    return -v;
  endfunction

  assign ev_num = num_pulse && !clr_pulse;
  assign ev_op  = op_pulse && !op_reserved(op_code) && !clr_pulse && !num_pulse;
  assign ev_neg = neg_pulse && !clr_pulse && !num_pulse && !ev_op;

  assign cnt_clr = clr_pulse || (state_q == S_EXEC);
  assign cnt_en  = (state_q == S_WAIT);

  calc_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .expired_o(tmo_expired)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    operand_d   = operand_q;
    opnd_vld_d  = opnd_vld_q;
    pend_op_d   = pend_op_q;
    next_op_d   = next_op_q;
    disp_d      = disp_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    alu_start_d = 1'b0;
    err_d       = err_q;

    case (state_q)
      S_A: begin
        if (ev_num) begin
          operand_d  = sw_val;
          opnd_vld_d = 1'b1;
          disp_d     = sw_val;
        end else if (ev_op) begin
          if (op_code != OP_EQ) begin
            acc_d      = operand_q;
            pend_op_d  = op_code;
            opnd_vld_d = 1'b0;
            disp_d     = operand_q;
            state_d    = S_B;
          end
        end else if (ev_neg) begin
          operand_d = neg_wrap(operand_q);
          disp_d    = neg_wrap(operand_q);
        end
      end

      S_B: begin
        if (ev_num) begin
          operand_d  = sw_val;
          opnd_vld_d = 1'b1;
          disp_d     = sw_val;
        end else if (ev_op) begin
          if (!opnd_vld_q) begin
            if (op_code != OP_EQ) begin
              pend_op_d = op_code;
            end
          end else if ((pend_op_q == OP_DIV) && (operand_q == '0)) begin
            // Division by zero is caught here so the ALU is never launched.
            state_d = S_ERR;
            err_d   = 1'b1;
            disp_d  = '0;
          end else begin
            alu_start_d = 1'b1;
            alu_a_d     = acc_q;
            alu_b_d     = operand_q;
            alu_op_d    = pend_op_q;
            next_op_d   = op_code;
            state_d     = S_EXEC;
          end
        end else if (ev_neg) begin
          operand_d = neg_wrap(operand_q);
          disp_d    = neg_wrap(operand_q);
        end
      end

      S_EXEC: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (alu_done) begin
          if (alu_err) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            disp_d  = '0;
          end else begin
            acc_d  = alu_result;
            disp_d = alu_result;
            if (next_op_q == OP_EQ) begin
              state_d = S_RES;
            end else begin
              pend_op_d  = next_op_q;
              opnd_vld_d = 1'b0;
              state_d    = S_B;
            end
          end
        end else if (tmo_expired) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          disp_d  = '0;
        end
      end

      S_RES: begin
        if (ev_num) begin
          operand_d  = sw_val;
          opnd_vld_d = 1'b1;
          disp_d     = sw_val;
          state_d    = S_A;
        end else if (ev_op) begin
          if (op_code != OP_EQ) begin
            pend_op_d  = op_code;
            opnd_vld_d = 1'b0;
            state_d    = S_B;
          end
        end else if (ev_neg) begin
          acc_d  = neg_wrap(acc_q);
          disp_d = neg_wrap(acc_q);
        end
      end

      S_ERR: begin
        err_d  = 1'b1;
        disp_d = '0;
      end

      default: begin
        state_d = S_A;
      end
    endcase

    // Clear behaves like reset from any state, abandoning an in-flight ALU operation.
    if (clr_pulse) begin
      state_d     = S_A;
      acc_d       = '0;
      operand_d   = '0;
      opnd_vld_d  = 1'b0;
      pend_op_d   = OP_EQ;
      next_op_d   = OP_EQ;
      disp_d      = '0;
      alu_a_d     = '0;
      alu_b_d     = '0;
      alu_op_d    = OP_EQ;
      alu_start_d = 1'b0;
      err_d       = 1'b0;
    end

    busy_d = (state_d == S_EXEC) || (state_d == S_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_A;
      acc_q       <= '0;
      operand_q   <= '0;
      opnd_vld_q  <= 1'b0;
      pend_op_q   <= OP_EQ;
      next_op_q   <= OP_EQ;
      disp_q      <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= OP_EQ;
      alu_start_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      operand_q   <= operand_d;
      opnd_vld_q  <= opnd_vld_d;
      pend_op_q   <= pend_op_d;
      next_op_q   <= next_op_d;
      disp_q      <= disp_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      alu_start_q <= alu_start_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign alu_start = alu_start_q;
  assign disp_val  = disp_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Bench for calc_seq_ctrl: directed scenarios plus random key sequences against a calculator model.
module tb_calc_seq_ctrl;

  localparam int W  = 10;
  localparam int TO = 8;

  localparam logic [2:0] C_EQ  = 3'b000;
  localparam logic [2:0] C_ADD = 3'b010;
  localparam logic [2:0] C_SUB = 3'b011;
  localparam logic [2:0] C_DIV = 3'b100;
  localparam logic [2:0] C_MUL = 3'b101;

  localparam int P_FIRST  = 0;
  localparam int P_SECOND = 1;
  localparam int P_RESULT = 2;
  localparam int P_ERROR  = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [W-1:0]        sw_val;
  logic                num_pulse, op_pulse, neg_pulse, clr_pulse;
  logic [2:0]          op_code;
  logic signed [W-1:0] alu_a, alu_b, alu_result, disp_val;
  logic [2:0]          alu_op;
  logic                alu_start, alu_done, alu_err, err, busy;

  int checks   = 0;
  int failures = 0;

  int resp_delay  = 3;
  int resp_left   = 0;
  bit resp_active = 1'b0;

  logic signed [W-1:0] m_acc, m_opnd, m_disp, m_ea, m_eb;
  logic [2:0]          m_pend, m_eop;
  bit                  m_vld, m_err, m_launch;
  int                  m_phase;

  calc_seq_ctrl #(
    .W      (W),
    .TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_val    (sw_val),
    .num_pulse (num_pulse),
    .op_pulse  (op_pulse),
    .op_code   (op_code),
    .neg_pulse (neg_pulse),
    .clr_pulse (clr_pulse),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_start (alu_start),
    .alu_done  (alu_done),
    .alu_result(alu_result),
    .alu_err   (alu_err),
    .disp_val  (disp_val),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Calculator arithmetic on whole integers; overflow when the true result leaves W bits.
  function automatic void alu_calc(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                                   input logic [2:0] op, output logic signed [W-1:0] r,
                                   output logic ovf);
    int ia, ib, ir;
    ia = int'(a);
    ib = int'(b);
    case (op)
      C_ADD:   ir = ia + ib;
      C_SUB:   ir = ia - ib;
      C_MUL:   ir = ia * ib;
      C_DIV:   ir = (ib == 0) ? 0 : ia / ib;
      default: ir = 0;
    endcase
    ovf = (ir > (2 ** (W - 1)) - 1) || (ir < -(2 ** (W - 1)));
    r = W'(ir);
  endfunction

  function automatic bit is_reserved(input logic [2:0] c);
    return !(c == C_EQ || c == C_ADD || c == C_SUB || c == C_DIV || c == C_MUL);
  endfunction

  function automatic void m_clr();
    m_acc = '0; m_opnd = '0; m_disp = '0; m_pend = C_EQ;
    m_vld = 1'b0; m_err = 1'b0; m_launch = 1'b0; m_phase = P_FIRST;
  endfunction

  function automatic void m_fail();
    m_phase = P_ERROR; m_err = 1'b1; m_disp = '0;
  endfunction

  function automatic void m_num(input logic [W-1:0] v);
    m_launch = 1'b0;
    if (m_phase == P_ERROR) return;
    m_opnd = v; m_vld = 1'b1; m_disp = v;
    if (m_phase == P_RESULT) m_phase = P_FIRST;
  endfunction

  function automatic void m_neg();
    m_launch = 1'b0;
    if (m_phase == P_FIRST || m_phase == P_SECOND) begin
      m_opnd = -m_opnd; m_disp = m_opnd;
    end else if (m_phase == P_RESULT) begin
      m_acc = -m_acc; m_disp = m_acc;
    end
  endfunction

  function automatic void m_op(input logic [2:0] c);
    logic signed [W-1:0] r;
    logic ovf;
    m_launch = 1'b0;
    if (is_reserved(c) || m_phase == P_ERROR) return;
    if (m_phase == P_FIRST) begin
      if (c != C_EQ) begin
        m_acc = m_opnd; m_pend = c; m_vld = 1'b0; m_disp = m_opnd; m_phase = P_SECOND;
      end
    end else if (m_phase == P_RESULT) begin
      if (c != C_EQ) begin
        m_pend = c; m_vld = 1'b0; m_phase = P_SECOND;
      end
    end else if (!m_vld) begin
      if (c != C_EQ) m_pend = c;
    end else if (m_pend == C_DIV && m_opnd == 0) begin
      m_fail();
    end else begin
      m_launch = 1'b1; m_ea = m_acc; m_eb = m_opnd; m_eop = m_pend;
      alu_calc(m_acc, m_opnd, m_pend, r, ovf);
      if (ovf) begin
        m_fail();
      end else begin
        m_acc = r; m_disp = r;
        if (c == C_EQ) m_phase = P_RESULT;
        else begin
          m_pend = c; m_vld = 1'b0;
        end
      end
    end
  endfunction

  task automatic pulse_end();
    @(negedge clk);
    num_pulse = 1'b0; op_pulse = 1'b0; neg_pulse = 1'b0; clr_pulse = 1'b0;
  endtask

  task automatic settle_check(input string tag);
    if (m_launch) begin
      chk1({tag, ".start"}, alu_start, 1'b1);
      chk({tag, ".a"}, alu_a, m_ea);
      chk({tag, ".b"}, alu_b, m_eb);
      chk({tag, ".op"}, W'(alu_op), W'(m_eop));
      @(negedge clk);
      chk1({tag, ".start_1cyc"}, alu_start, 1'b0);
    end else begin
      chk1({tag, ".nostart"}, alu_start, 1'b0);
    end
    for (int i = 0; i < 100 && busy === 1'b1; i++) @(negedge clk);
    chk1({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".disp"}, disp_val, m_disp);
    chk1({tag, ".err"}, err, m_err);
  endtask

  task automatic ev_num(input logic [W-1:0] v, input string tag);
    @(negedge clk);
    sw_val = v; num_pulse = 1'b1;
    m_num(v);
    pulse_end();
    settle_check(tag);
  endtask

  task automatic ev_op(input logic [2:0] c, input string tag);
    @(negedge clk);
    op_code = c; op_pulse = 1'b1;
    m_op(c);
    pulse_end();
    settle_check(tag);
  endtask

  task automatic ev_neg(input string tag);
    @(negedge clk);
    neg_pulse = 1'b1;
    m_neg();
    pulse_end();
    settle_check(tag);
  endtask

  task automatic ev_clr(input string tag);
    @(negedge clk);
    clr_pulse = 1'b1;
    m_clr();
    pulse_end();
    settle_check(tag);
  endtask

  task automatic launch_eq_raw();
    @(negedge clk);
    op_code = C_EQ; op_pulse = 1'b1;
    pulse_end();
  endtask

  // ALU stand-in: answers resp_delay cycles after each start strobe (0 means never).
  initial begin
    alu_done = 1'b0; alu_result = '0; alu_err = 1'b0;
    forever begin
      @(negedge clk);
      alu_done = 1'b0;
      if (resp_active) begin
        resp_left--;
        if (resp_left == 0) begin
          alu_calc(alu_a, alu_b, alu_op, alu_result, alu_err);
          alu_done = 1'b1;
          resp_active = 1'b0;
        end
      end else if (alu_start === 1'b1 && resp_delay > 0) begin
        resp_active = 1'b1;
        resp_left = resp_delay;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; sw_val = '0; op_code = C_EQ;
    num_pulse = 1'b0; op_pulse = 1'b0; neg_pulse = 1'b0; clr_pulse = 1'b0;
    m_clr();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.disp", disp_val, '0);
    chk1("rst.err", err, 1'b0);
    chk1("rst.busy", busy, 1'b0);
    chk1("rst.start", alu_start, 1'b0);
    chk("rst.a", alu_a, '0);
    chk("rst.b", alu_b, '0);
    chk("rst.op", W'(alu_op), '0);
    rst_n = 1'b1;

    // Basic add, ALU answering after 3 cycles
    resp_delay = 3;
    ev_num(W'(5), "add.num5");
    ev_op(C_ADD, "add.opadd");
    ev_num(W'(3), "add.num3");
    ev_op(C_EQ, "add.eq");
    chk("add.lit8", disp_val, W'(8));
    ev_neg("add.res_neg");
    chk("add.lit_m8", disp_val, 10'h3F8);

    // Chaining
    ev_clr("chain.clr");
    ev_num(W'(7), "chain.num7");
    ev_op(C_SUB, "chain.sub");
    ev_num(W'(2), "chain.num2");
    ev_op(C_MUL, "chain.mul");
    chk("chain.lit5", disp_val, W'(5));
    ev_num(W'(4), "chain.num4");
    ev_op(C_EQ, "chain.eq");
    chk("chain.lit20", disp_val, W'(20));

    // Divide by zero
    ev_clr("div0.clr");
    ev_num(W'(9), "div0.num9");
    ev_op(C_DIV, "div0.div");
    ev_num(W'(0), "div0.num0");
    ev_op(C_EQ, "div0.eq");
    chk1("div0.err_lit", err, 1'b1);
    ev_num(W'(6), "div0.num_ignored");
    ev_clr("div0.clr2");
    ev_num(W'(3), "div0.num3");
    ev_op(C_ADD, "div0.after_clr_op");

    // Abort with clr in the second wait cycle; the late done must be ignored
    ev_clr("abort.clr0");
    resp_delay = 10;
    ev_num(W'(4), "abort.num4");
    ev_op(C_ADD, "abort.add");
    ev_num(W'(1), "abort.num1");
    launch_eq_raw();
    chk1("abort.start", alu_start, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk1("abort.busy_w2", busy, 1'b1);
    clr_pulse = 1'b1;
    @(negedge clk);
    clr_pulse = 1'b0;
    m_clr();
    chk1("abort.busy", busy, 1'b0);
    chk("abort.disp", disp_val, '0);
    chk("abort.a", alu_a, '0);
    repeat (12) @(negedge clk);
    chk("abort.late_disp", disp_val, '0);
    chk1("abort.late_busy", busy, 1'b0);
    ev_num(W'(6), "abort.state_a_num");
    ev_op(C_SUB, "abort.state_a_op");

    // Asynchronous reset in the middle of a wait
    ev_clr("arst.clr0");
    ev_num(W'(2), "arst.num2");
    ev_op(C_ADD, "arst.add");
    ev_num(W'(3), "arst.num3");
    launch_eq_raw();
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.disp", disp_val, '0);
    chk1("arst.busy", busy, 1'b0);
    chk1("arst.start", alu_start, 1'b0);
    chk("arst.a", alu_a, '0);
    chk("arst.b", alu_b, '0);
    chk("arst.op", W'(alu_op), '0);
    chk1("arst.err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    m_clr();
    repeat (12) @(negedge clk);
    chk("arst.late_disp", disp_val, '0);

    // Timeout: ALU never answers
    resp_delay = 0;
    ev_num(W'(1), "tmo.num1");
    ev_op(C_ADD, "tmo.add");
    ev_num(W'(1), "tmo.num1b");
    launch_eq_raw();
    chk1("tmo.start", alu_start, 1'b1);
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      chk1("tmo.noerr", err, 1'b0);
      chk1("tmo.busy", busy, 1'b1);
    end
    @(negedge clk);
    chk1("tmo.err", err, 1'b1);
    chk("tmo.disp", disp_val, '0);
    chk1("tmo.busy_low", busy, 1'b0);
    m_fail();
    ev_clr("tmo.clr");
    resp_delay = 3;

    // Negation and wrap
    ev_num(W'(12), "neg.num12");
    ev_neg("neg.n1");
    chk("neg.lit3f4", disp_val, 10'h3F4);
    ev_neg("neg.n2");
    chk("neg.lit12", disp_val, W'(12));
    ev_num(10'h200, "neg.num200");
    ev_neg("neg.wrap");
    chk("neg.lit200", disp_val, 10'h200);

    // Priority: num over op, clr over num
    ev_clr("prio.clr0");
    ev_num(W'(5), "prio.num5");
    @(negedge clk);
    sw_val = W'(7); num_pulse = 1'b1; op_pulse = 1'b1; op_code = C_ADD;
    m_num(W'(7));
    pulse_end();
    settle_check("prio.num_op");
    ev_op(C_SUB, "prio.sub");
    ev_num(W'(2), "prio.num2");
    ev_op(C_EQ, "prio.eq");
    @(negedge clk);
    sw_val = W'(9); num_pulse = 1'b1; clr_pulse = 1'b1;
    m_clr();
    pulse_end();
    settle_check("prio.clr_num");

    // Random key sequences
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [W-1:0] v;
      r = $urandom_range(0, 99);
      resp_delay = $urandom_range(1, 6);
      if (r < 35) begin
        if ($urandom_range(0, 3) == 0) v = W'($urandom);
        else v = W'($urandom_range(0, 40)) - W'(20);
        ev_num(v, "rnd.num");
      end else if (r < 75) begin
        ev_op(3'($urandom_range(0, 7)), "rnd.op");
      end else if (r < 93) begin
        ev_neg("rnd.neg");
      end else begin
        ev_clr("rnd.clr");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
